serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor built around a single full-subtractor cell and a registered borrow. It is the subtract counterpart to the full-adder datapath: one difference bit is produced per clock, LSB first. It sits alongside the adder cells in the arithmetic library and is driven by a start/busy/done handshake from a controller or testbench.

---
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell and a registered borrow.
// One difference bit is produced per clock, LSB first, under a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q;
    logic [WIDTH-1:0] sb_q;
    logic [WIDTH-1:0] sd_q;
    logic [WIDTH-1:0] sd_d;
    logic [WIDTH-1:0] diff_q;
    logic             br_q;
    logic             bout_q;
    logic [CW-1:0]    cnt_q;
    logic             d;
    logic             nb;
    logic             last;

    always_comb begin
        d    = sa_q[0] ^ sb_q[0] ^ br_q;
        nb   = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
        last = (cnt_q == CW'(WIDTH - 1));
    end

    // A single-bit result register has no upper bits to shift down.
    generate
        if (WIDTH == 1) begin : g_sd_w1
            assign sd_d = d;
        end else begin : g_sd_wn
            assign sd_d = {d, sd_q[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    sd_q  <= sd_d;
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    br_q  <= nb;
                    cnt_q <= cnt_q + CW'(1);
                    // Results publish only here, so diff/bout hold across the next operation.
                    if (last) begin
                        diff_q  <= sd_d;
                        bout_q  <= nb;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH 8, 4 and 1.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;

    logic       start8, bin8, bout8, busy8, done8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, bout4, busy4, done4;
    logic [3:0] a4, b4, diff4;
    logic       start1, bin1, bout1, busy1, done1;
    logic [0:0] a1, b1, diff1;

    int passed;
    int total;

    serial_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
    );
    serial_subtractor #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
    );
    serial_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .bin(bin1),
        .diff(diff1), .bout(bout1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full 8-bit operation from IDLE; entered and left at #1 after an edge.
    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic [7:0] ed, input logic eb);
        int n;
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        step();
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 20) begin
            step();
            n++;
        end
        chk({tag, " busy_cycles"}, n, 8);
        chk({tag, " done"}, done8, 1);
        chk({tag, " diff"}, diff8, ed);
        chk({tag, " bout"}, bout8, eb);
        step();
        chk({tag, " done_drop"}, done8, 0);
    endtask

    initial begin
        int n;
        logic [4:0] exp5;
        passed = 0; total = 0;
        rst = 1'b1;
        start8 = 0; a8 = '0; b8 = '0; bin8 = 0;
        start4 = 0; a4 = '0; b4 = '0; bin4 = 0;
        start1 = 0; a1 = '0; b1 = '0; bin1 = 0;

        repeat (2) step();
        chk("rst diff", diff8, 0);
        chk("rst bout", bout8, 0);
        chk("rst busy", busy8, 0);
        chk("rst done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        op8("5A-3C", 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);
        op8("00-01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        op8("00-FF-1", 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1);
        op8("10-0F-1", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);

        // Second start on the 3rd busy cycle must be ignored.
        a8 = 8'h80; b8 = 8'h01; bin8 = 0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step();
        step();
        chk("ign busy3", busy8, 1);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("ign diff_hold", diff8, 8'h00);
        n = 3;
        while (!done8 && n < 20) begin
            step();
            n++;
        end
        chk("ign done_edge", n, 8);
        chk("ign diff", diff8, 8'h7F);
        chk("ign bout", bout8, 0);
        step();
        chk("ign idle_busy", busy8, 0);
        step();
        chk("ign no_restart", busy8, 0);

        // Asynchronous reset during the 4th SHIFT cycle.
        a8 = 8'hF0; b8 = 8'h0F; bin8 = 0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        chk("abort busy4", busy8, 1);
        #2 rst = 1'b1;
        #1;
        chk("abort diff", diff8, 0);
        chk("abort bout", bout8, 0);
        chk("abort busy", busy8, 0);
        chk("abort done", done8, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            step();
            if (done8) n++;
        end
        chk("abort no_done", n, 0);
        op8("03-01", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0);

        // Continuous start: one result every WIDTH+2 cycles.
        a8 = 8'h0A; b8 = 8'h05; bin8 = 0; start8 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!done8 && n < 30) begin
                step();
                n++;
            end
            chk($sformatf("cont%0d edges", k), n, 9);
            chk($sformatf("cont%0d diff", k), diff8, 8'h05);
            chk($sformatf("cont%0d busy_done", k), busy8, 0);
            if (k == 2) start8 = 1'b0;
            step();
            chk($sformatf("cont%0d busy_idle", k), busy8, 0);
            chk($sformatf("cont%0d done_idle", k), done8, 0);
        end

        // WIDTH=4 exhaustive.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
                    step();
                    start4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 10) begin
                        step();
                        n++;
                    end
                    exp5 = 5'(ia - ib - ic);
                    chk($sformatf("w4 %0d-%0d-%0d", ia, ib, ic), {bout4, diff4}, exp5);
                    step();
                end
            end
        end

        // WIDTH=1 smoke test.
        a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("w1 busy", busy1, 1);
        step();
        chk("w1 done", done1, 1);
        chk("w1 diff", diff1, 1);
        chk("w1 bout", bout1, 1);
        step();
        chk("w1 done_drop", done1, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
